// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: instruction-fetch PC sequencer with a one-entry output buffer.
//
// Drives the shared PC ALU (pc+4 by default, redirect operands when the
// execute stage redirects), issues instruction-memory requests, and
// buffers one fetched word for decode.
//
// States: IDLE (after reset), FETCH (request outstanding), STALL (buffer
// full and the acked word dropped, PC held for re-fetch), DRAIN (redirected
// while a request was in flight; the in-flight word is thrown away).
//
// Ports:
//   i_clock, i_reset            clock (rising edge), async active-low reset
//   i_redirect/Op/Pc            execute-stage redirect and its PC-ALU operands
//   i_trap                      trap request (only with PC_TRAP_EN defined)
//   o_aluOp, o_aluPc            operands to the shared PC ALU
//   i_aluResult                 PC ALU result (combinational)
//   o_memReq, o_memAddr         instruction-memory request/address
//   i_memAck, i_memData         memory acceptance and fetched word
//   o_instValid/o_inst/o_instPc output buffer to decode
//   i_instReady                 decode consumes the buffer
//
// Configuration macro: PC_TRAP_EN adds i_trap, which jumps to TRAP_VECTOR
// with priority over i_redirect.

module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [1:0]  i_redirectOp,
  input  logic [31:0] i_redirectPc,
`ifdef PC_TRAP_EN
  input  logic        i_trap,
`endif
  output logic [1:0]  o_aluOp,
  output logic [31:0] o_aluPc,
  input  logic [31:0] i_aluResult,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memAck,
  input  logic [31:0] i_memData,
  output logic        o_instValid,
  output logic [31:0] o_inst,
  output logic [31:0] o_instPc,
  input  logic        i_instReady
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        flush;     // any control-flow change this cycle
  logic [31:0] flush_pc;  // its word-aligned target

`ifdef PC_TRAP_EN
  assign flush    = i_trap | i_redirect;
  assign flush_pc = i_trap ? TRAP_VECTOR : {i_aluResult[31:2], 2'b00};
`else
  assign flush    = i_redirect;
  assign flush_pc = {i_aluResult[31:2], 2'b00};
`endif

  // The ALU is shared: redirect operands win, otherwise compute pc+4.
  assign o_aluOp = i_redirect ? i_redirectOp : 2'b00;
  assign o_aluPc = i_redirect ? i_redirectPc : pc;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      o_memReq    <= 1'b0;
      o_memAddr   <= RESET_VECTOR;
      o_instValid <= 1'b0;
      o_inst      <= '0;
      o_instPc    <= '0;
    end else begin
      // Decode drains the buffer; a load below re-sets it.
      if (i_instReady) o_instValid <= 1'b0;

      if (flush) begin
        pc          <= flush_pc;
        o_instValid <= 1'b0;
        if ((state == FETCH || state == DRAIN) && !i_memAck) begin
          // Request still in flight: hold address until memory takes it,
          // then discard the word.
          state <= DRAIN;
        end else begin
          // Nothing in flight (or the ack lands now and is dropped).
          state     <= FETCH;
          o_memReq  <= 1'b1;
          o_memAddr <= flush_pc;
        end
      end else begin
        case (state)
          IDLE: begin
            state     <= FETCH;
            o_memReq  <= 1'b1;
            o_memAddr <= pc;
          end
          FETCH: begin
            if (i_memAck) begin
              if (!o_instValid || i_instReady) begin
                o_inst      <= i_memData;
                o_instPc    <= o_memAddr;
                o_instValid <= 1'b1;
                pc          <= i_aluResult;
                o_memAddr   <= i_aluResult;
              end else begin
                // No room for the word: drop it and re-fetch the same PC.
                state    <= STALL;
                o_memReq <= 1'b0;
              end
            end
          end
          STALL: begin
            if (i_instReady) begin
              state     <= FETCH;
              o_memReq  <= 1'b1;
              o_memAddr <= pc;
            end
          end
          DRAIN: begin
            if (i_memAck) begin
              state     <= FETCH;
              o_memAddr <= pc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, hand-written multi-cycle
// sequences (drain, wrap, reset mid-access, trap), then randomized traffic
// checked against a rule-level reference model.

module tb_fetch_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_redirect = 1'b0;
  logic [1:0]  i_redirectOp = 2'b00;
  logic [31:0] i_redirectPc = '0;
  logic [1:0]  o_aluOp;
  logic [31:0] o_aluPc;
  logic [31:0] i_aluResult;
  logic        o_memReq;
  logic [31:0] o_memAddr;
  logic        i_memAck = 1'b0;
  logic [31:0] i_memData = '0;
  logic        o_instValid;
  logic [31:0] o_inst;
  logic [31:0] o_instPc;
  logic        i_instReady = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] redir_res = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clock = ~i_clock;

  // PC ALU stand-in: pc+4 for op 00, otherwise the result chosen by the test.
  assign i_aluResult = (o_aluOp == 2'b00) ? o_aluPc + 32'd4 : redir_res;

  fetch_pc_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_redirect(i_redirect), .i_redirectOp(i_redirectOp), .i_redirectPc(i_redirectPc),
`ifdef PC_TRAP_EN
    .i_trap(trap),
`endif
    .o_aluOp(o_aluOp), .o_aluPc(o_aluPc), .i_aluResult(i_aluResult),
    .o_memReq(o_memReq), .o_memAddr(o_memAddr),
    .i_memAck(i_memAck), .i_memData(i_memData),
    .o_instValid(o_instValid), .o_inst(o_inst), .o_instPc(o_instPc),
    .i_instReady(i_instReady)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic drive(input logic ack, input logic rdy, input logic rd, input logic [1:0] op,
                       input logic [31:0] rpc, input logic [31:0] rres, input logic [31:0] data);
    @(negedge i_clock);
    i_memAck = ack; i_instReady = rdy; i_redirect = rd; i_redirectOp = op;
    i_redirectPc = rpc; redir_res = rres; i_memData = data;
  endtask

  task automatic run(input logic ack, input logic rdy, input logic rd, input logic [1:0] op,
                     input logic [31:0] rpc, input logic [31:0] rres, input logic [31:0] data);
    drive(ack, rdy, rd, op, rpc, rres, data);
    @(posedge i_clock); #1;
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    i_reset = 1'b0; i_memAck = 1'b0; i_instReady = 1'b0; i_redirect = 1'b0; trap = 1'b0;
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  logic        m_req, m_valid, m_stalled, m_drain;
  logic [31:0] m_addr, m_pc, m_inst, m_ipc;

  task automatic model_reset();
    m_req = 0; m_valid = 0; m_stalled = 0; m_drain = 0;
    m_addr = RV; m_pc = RV; m_inst = '0; m_ipc = '0;
  endtask

  // One clock edge of fetch behaviour, expressed as the control-flow rules.
  task automatic model_step(input logic ack, input logic rdy, input logic rd, input logic tr,
                            input logic [31:0] rres);
    logic [31:0] tgt;
    logic        nv;
    tgt = tr ? TV : (rres & ~32'd3);
    nv  = m_valid && !rdy;
    if (rd || tr) begin
      m_pc = tgt; nv = 0;
      if (m_req && !ack) m_drain = 1;
      else begin m_drain = 0; m_stalled = 0; m_req = 1; m_addr = tgt; end
    end else if (m_drain) begin
      if (ack) begin m_drain = 0; m_addr = m_pc; end
    end else if (!m_req) begin
      if (!m_stalled || rdy) begin m_stalled = 0; m_req = 1; m_addr = m_pc; end
    end else if (ack) begin
      if (!m_valid || rdy) begin
        nv = 1; m_inst = mem_word(m_addr); m_ipc = m_addr;
        m_pc = m_addr + 32'd4; m_addr = m_pc;
      end else begin
        m_stalled = 1; m_req = 0;
      end
    end
    m_valid = nv;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        ack, rdy, rd;
    logic [1:0]  op;
    logic [31:0] rpc, rres, data;
    logic [1:0]  e_op;
    logic [31:0] e_apc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc, e_inst;
  } vec_t;

  vec_t vt[13];

  initial begin
    //          ack rdy rd op     rpc    rres    data          e_op  e_apc  req addr   v  ipc    inst
    vt[0]  = '{1, 1, 0, 2'b00, 0,     0,      32'hEEEE_EEEE, 2'b00, 0,     1, 32'h0,  0, 32'h0,  32'h0};
    vt[1]  = '{1, 1, 0, 2'b00, 0,     0,      32'h1000_0000, 2'b00, 0,     1, 32'h4,  1, 32'h0,  32'h1000_0000};
    vt[2]  = '{1, 1, 0, 2'b00, 0,     0,      32'h1000_0004, 2'b00, 4,     1, 32'h8,  1, 32'h4,  32'h1000_0004};
    vt[3]  = '{1, 0, 0, 2'b00, 0,     0,      32'h1000_0008, 2'b00, 8,     0, 32'h8,  1, 32'h4,  32'h1000_0004};
    vt[4]  = '{0, 0, 0, 2'b00, 0,     0,      32'h0,         2'b00, 8,     0, 32'h8,  1, 32'h4,  32'h1000_0004};
    vt[5]  = '{0, 0, 0, 2'b00, 0,     0,      32'h0,         2'b00, 8,     0, 32'h8,  1, 32'h4,  32'h1000_0004};
    vt[6]  = '{0, 1, 0, 2'b00, 0,     0,      32'h0,         2'b00, 8,     1, 32'h8,  0, 32'h4,  32'h1000_0004};
    vt[7]  = '{1, 1, 0, 2'b00, 0,     0,      32'h1000_0008, 2'b00, 8,     1, 32'hC,  1, 32'h8,  32'h1000_0008};
    vt[8]  = '{1, 0, 1, 2'b01, 32'h10, 32'h40, 32'hBAD0_BAD0, 2'b01, 32'h10, 1, 32'h40, 0, 32'h8, 32'h1000_0008};
    vt[9]  = '{1, 1, 0, 2'b00, 0,     0,      32'h2000_0040, 2'b00, 32'h40, 1, 32'h44, 1, 32'h40, 32'h2000_0040};
    vt[10] = '{1, 0, 1, 2'b11, 32'h80, 32'h103, 32'hBAD1_BAD1, 2'b11, 32'h80, 1, 32'h100, 0, 32'h40, 32'h2000_0040};
    vt[11] = '{0, 0, 0, 2'b00, 0,     0,      32'h0,         2'b00, 32'h100, 1, 32'h100, 0, 32'h40, 32'h2000_0040};
    vt[12] = '{1, 0, 0, 2'b00, 0,     0,      32'h3000_0100, 2'b00, 32'h100, 1, 32'h104, 1, 32'h100, 32'h3000_0100};

    // Reset values, sampled while reset is held.
    #12;
    chk("rst_memReq", o_memReq, 0);
    chk("rst_memAddr", o_memAddr, RV);
    chk("rst_instValid", o_instValid, 0);
    chk("rst_inst", o_inst, 0);
    chk("rst_instPc", o_instPc, 0);
    do_reset();

    foreach (vt[i]) begin
      drive(vt[i].ack, vt[i].rdy, vt[i].rd, vt[i].op, vt[i].rpc, vt[i].rres, vt[i].data);
      #1;
      chk($sformatf("v%0d_aluOp", i), o_aluOp, vt[i].e_op);
      chk($sformatf("v%0d_aluPc", i), o_aluPc, vt[i].e_apc);
      @(posedge i_clock); #1;
      chk($sformatf("v%0d_memReq", i), o_memReq, vt[i].e_req);
      chk($sformatf("v%0d_memAddr", i), o_memAddr, vt[i].e_addr);
      chk($sformatf("v%0d_instValid", i), o_instValid, vt[i].e_valid);
      chk($sformatf("v%0d_instPc", i), o_instPc, vt[i].e_ipc);
      chk($sformatf("v%0d_inst", i), o_inst, vt[i].e_inst);
    end

    // Redirect during an unacked request, a second redirect while draining,
    // then the late ack whose word must be discarded.
    run(1, 1, 1, 2'b01, 32'h4, 32'h20, 32'hBAD2_BAD2);
    chk("drn_setup_addr", o_memAddr, 32'h20);
    run(0, 0, 1, 2'b01, 32'h4, 32'h60, 32'h0);
    chk("drn_enter_req", o_memReq, 1);
    chk("drn_enter_addr", o_memAddr, 32'h20);
    chk("drn_enter_valid", o_instValid, 0);
    run(0, 0, 1, 2'b11, 32'h8, 32'h80, 32'h0);
    chk("drn_retarget_addr", o_memAddr, 32'h20);
    run(1, 1, 0, 2'b00, 0, 0, 32'h0000_DEAD);
    chk("drn_ack_addr", o_memAddr, 32'h80);
    chk("drn_ack_valid", o_instValid, 0);
    chk("drn_ack_inst", o_inst, 32'h3000_0100);
    run(1, 1, 0, 2'b00, 0, 0, 32'h0000_8080);
    chk("drn_next_instPc", o_instPc, 32'h80);
    chk("drn_next_inst", o_inst, 32'h0000_8080);

    // Wraparound at the top of the address space.
    run(1, 1, 1, 2'b11, 32'h0, 32'hFFFF_FFFE, 32'h0);
    chk("wrap_top_addr", o_memAddr, 32'hFFFF_FFFC);
    run(1, 1, 0, 2'b00, 0, 0, 32'h0000_F0F0);
    chk("wrap_addr", o_memAddr, 32'h0);
    chk("wrap_instPc", o_instPc, 32'hFFFF_FFFC);
    run(1, 1, 0, 2'b00, 0, 0, 32'h0000_1111);
    chk("wrap_next_addr", o_memAddr, 32'h4);

    // Asynchronous reset in the middle of an access; acks ignored meanwhile.
    @(negedge i_clock);
    i_memAck = 1'b1;
    #2 i_reset = 1'b0;
    #1;
    chk("arst_memReq", o_memReq, 0);
    chk("arst_memAddr", o_memAddr, RV);
    chk("arst_instValid", o_instValid, 0);
    chk("arst_inst", o_inst, 0);
    chk("arst_instPc", o_instPc, 0);
    @(posedge i_clock); #1;
    chk("arst_hold_req", o_memReq, 0);
    @(posedge i_clock); #1 i_reset = 1'b1;
    run(1, 1, 0, 2'b00, 0, 0, 32'h7777_7777);
    chk("idle_exit_req", o_memReq, 1);
    chk("idle_exit_addr", o_memAddr, RV);
    chk("idle_exit_valid", o_instValid, 0);
    run(1, 1, 0, 2'b00, 0, 0, 32'h5555_0000);
    chk("post_rst_addr", o_memAddr, 32'h4);
    chk("post_rst_instPc", o_instPc, RV);

`ifdef PC_TRAP_EN
    drive(1, 1, 1, 2'b01, 32'h4, 32'h40, 32'h0);
    trap = 1'b1;
    @(posedge i_clock); #1;
    trap = 1'b0;
    chk("trap_addr", o_memAddr, TV);
    chk("trap_valid", o_instValid, 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      logic        ack, rdy, rd, tr;
      logic [1:0]  op;
      logic [31:0] rpc, rres;
      ack = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 9) == 0);
      tr  = 1'b0;
`ifdef PC_TRAP_EN
      tr  = ($urandom_range(0, 29) == 0);
`endif
      op  = $urandom_range(0, 1) ? 2'b01 : 2'b11;
      rpc = $urandom;
      case ($urandom_range(0, 3))
        0: rres = $urandom_range(0, 32'hFFF);
        1: rres = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        2: rres = $urandom;
        default: rres = 32'h100 + $urandom_range(0, 63);
      endcase
      @(negedge i_clock);
      i_memAck = ack; i_instReady = rdy; i_redirect = rd; i_redirectOp = op;
      i_redirectPc = rpc; redir_res = rres; trap = tr;
      i_memData = mem_word(o_memAddr);
      #1;
      chk("rnd_aluOp", o_aluOp, rd ? op : 2'b00);
      chk("rnd_aluPc", o_aluPc, rd ? rpc : m_pc);
      @(posedge i_clock);
      model_step(ack, rdy, rd, tr, rres);
      #1;
      chk("rnd_memReq", o_memReq, m_req);
      chk("rnd_memAddr", o_memAddr, m_addr);
      chk("rnd_instValid", o_instValid, m_valid);
      if (m_valid) begin
        chk("rnd_instPc", o_instPc, m_ipc);
        chk("rnd_inst", o_inst, m_inst);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
